// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add controller for the EX-stage MUL: stalls the pipe, iterates, then presents the low product bits.
// Optional early termination on an exhausted multiplier is enabled by defining MUL_EARLY_EXIT_EN.
module mul_sequencer #(
  parameter int unsigned DATA_W   = 64,
  parameter logic [3:0]  MUL_CODE = 4'd8,
  parameter int unsigned CNT_W    = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              en,
  input  logic              flush,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              stall,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] w_mcand_nxt;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] w_mplier_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_req;
  logic [DATA_W-1:0] w_mplier_shr;
  logic [DATA_W-1:0] w_acc_add;
  logic              w_last;

  // Reset is folded into the request so the combinational stall drops the moment arst rises.
  assign w_req        = (alu_control == MUL_CODE) & en & ~flush & ~arst;
  assign w_mplier_shr = r_mplier >> 1;
  assign w_acc_add    = r_acc + r_mcand;

`ifdef MUL_EARLY_EXIT_EN
  assign w_last = (r_cnt == CNT_W'(1)) | (w_mplier_shr == '0);
`else
  assign w_last = (r_cnt == CNT_W'(1));
`endif

  assign busy = (r_state != S_IDLE);

  // State and datapath registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Next-state, datapath step and outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;
    stall        = 1'b0;
    result       = '0;
    result_valid = 1'b0;

    case (r_state)
      S_IDLE: begin
        stall = w_req;
        if (w_req) begin
          w_mcand_nxt  = operand_a;
          w_mplier_nxt = operand_b;
          w_acc_nxt    = '0;
          w_cnt_nxt    = CNT_W'(DATA_W);
`ifdef MUL_EARLY_EXIT_EN
          w_state_nxt  = (operand_b == '0) ? S_DONE : S_BUSY;
`else
          w_state_nxt  = S_BUSY;
`endif
        end
      end

      S_BUSY: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          stall        = 1'b1;
          if (r_mplier[0]) begin
            w_acc_nxt = w_acc_add;
          end
          w_mcand_nxt  = r_mcand << 1;
          w_mplier_nxt = w_mplier_shr;
          w_cnt_nxt    = r_cnt - CNT_W'(1);
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          result_valid = 1'b1;
          result       = r_acc;
          // The MUL leaves EX on this edge; IDLE sees the following instruction, not a retrigger.
          if (en) begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: a latency/product model checked every cycle plus directed vectors.
module tb_mul_sequencer;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         arst;
  logic         en;
  logic         flush;
  logic [3:0]   alu_control;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         stall;
  logic         busy;
  logic [W-1:0] result;
  logic         result_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_sequencer #(.DATA_W(W)) dut (
    .clk          (clk),
    .arst         (arst),
    .en           (en),
    .flush        (flush),
    .alu_control  (alu_control),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .stall        (stall),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Number of BUSY cycles a multiply by b occupies.
  function automatic int exp_busy(input logic [W-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int i = 0; i < W; i++) begin
      if (b[i]) h = i + 1;
    end
    return h;
`else
    return W;
`endif
  endfunction

  // Reference model: tracks remaining busy cycles, done-hold and the arithmetic product.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_prod = '0;

  always @(negedge clk) begin : model
    logic         e_stall;
    logic         e_busy;
    logic         e_rv;
    logic [W-1:0] e_res;
    bit           req;
    e_stall = 1'b0;
    e_busy  = 1'b0;
    e_rv    = 1'b0;
    e_res   = '0;
    req     = (alu_control == 4'd8) && en && !flush;
    if (arst) begin
      m_left = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      e_busy = 1'b1;
      if (!flush) begin
        e_rv  = 1'b1;
        e_res = m_prod;
      end
      if (flush || en) m_done = 1'b0;
    end else if (m_left > 0) begin
      e_busy  = 1'b1;
      e_stall = !flush;
      if (flush) begin
        m_left = 0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) m_done = 1'b1;
      end
    end else if (req) begin
      e_stall = 1'b1;
      m_prod  = operand_a * operand_b;
      m_left  = exp_busy(operand_b);
      m_done  = (m_left == 0);
    end
    chk("model_stall", W'(stall), W'(e_stall));
    chk("model_busy", W'(busy), W'(e_busy));
    chk("model_result_valid", W'(result_valid), W'(e_rv));
    chk("model_result", result, e_res);
  end

  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int n_stall, output logic [W-1:0] res, output bit got);
    @(posedge clk); #1;
    alu_control = 4'd8;
    operand_a   = a;
    operand_b   = b;
    en          = 1'b1;
    flush       = 1'b0;
    n_stall     = 0;
    res         = '0;
    got         = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (result_valid) begin
        got = 1'b1;
        res = result;
      end
      @(posedge clk); #1;
    end
    alu_control = 4'd0;
    @(negedge clk);
    chk("post_done_stall", W'(stall), W'(0));
    chk("post_done_busy", W'(busy), W'(0));
    chk("post_done_valid", W'(result_valid), W'(0));
  endtask

  logic [W-1:0] va [6];
  logic [W-1:0] vb [6];
  logic [W-1:0] vp [6];

  initial begin : stim
    int           n;
    logic [W-1:0] r;
    bit           got;
    bit           seen;

    arst = 1'b1; en = 1'b0; flush = 1'b0;
    alu_control = 4'd0; operand_a = '0; operand_b = '0;

    va = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0,
           64'h1_0000_0000, 64'd123, 64'hFFFF_FFFF};
    vb = '{64'd6, 64'd2, 64'h10, 64'h1_0000_0000, 64'd0, 64'hFFFF_FFFF};
    vp = '{64'd42, 64'hFFFF_FFFF_FFFF_FFFE, 64'h2345_6789_ABCD_EF00,
           64'd0, 64'd0, 64'hFFFF_FFFE_0000_0001};

    @(negedge clk);
    chk("reset_stall", W'(stall), W'(0));
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_result", result, '0);
    chk("reset_valid", W'(result_valid), W'(0));
    @(posedge clk); #1;
    arst = 1'b0;
    en   = 1'b1;

    // 7x6 and -1x2 with pinned stall lengths
    do_mul(va[0], vb[0], n, r, got);
    chk("mul7x6_done", W'(got), W'(1));
    chk("mul7x6_result", r, 64'd42);
`ifdef MUL_EARLY_EXIT_EN
    chk("mul7x6_stall_cycles", W'(n), W'(4));
`else
    chk("mul7x6_stall_cycles", W'(n), W'(65));
`endif
    do_mul(va[1], vb[1], n, r, got);
    chk("mulm1x2_done", W'(got), W'(1));
    chk("mulm1x2_result", r, 64'hFFFF_FFFF_FFFF_FFFE);
`ifdef MUL_EARLY_EXIT_EN
    chk("mulm1x2_stall_cycles", W'(n), W'(3));
`else
    chk("mulm1x2_stall_cycles", W'(n), W'(65));
`endif

    for (int i = 2; i < 6; i++) begin
      do_mul(va[i], vb[i], n, r, got);
      chk("vec_done", W'(got), W'(1));
      chk("vec_result", r, vp[i]);
      chk("vec_stall_cycles", W'(n), W'(exp_busy(vb[i]) + 1));
    end

    // Non-MUL code never stalls
    @(posedge clk); #1;
    alu_control = 4'd2; operand_a = 64'd5; operand_b = 64'd5; en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("nonmul_stall", W'(stall), W'(0));
      chk("nonmul_busy", W'(busy), W'(0));
      chk("nonmul_valid", W'(result_valid), W'(0));
      @(posedge clk); #1;
    end

    // 5x5 with en low through BUSY and for three DONE cycles
    alu_control = 4'd8; operand_a = 64'd5; operand_b = 64'd5; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    n  = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (result_valid) begin
        n++;
        chk("hold_result", result, 64'd25);
      end
      if (n == 4) break;
      @(posedge clk); #1;
      if (n == 3) en = 1'b1;
    end
    chk("hold_valid_cycles", W'(n), W'(4));
    @(posedge clk); #1;
    alu_control = 4'd0;
    @(negedge clk);
    chk("hold_exit_busy", W'(busy), W'(0));
    chk("hold_exit_valid", W'(result_valid), W'(0));

    // Flush in the tenth BUSY cycle
    @(posedge clk); #1;
    alu_control = 4'd8; operand_a = 64'd9; operand_b = 64'h8000_0000_0000_0001; en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", W'(stall), W'(0));
    chk("flush_valid", W'(result_valid), W'(0));
    chk("flush_busy", W'(busy), W'(1));
    @(posedge clk); #1;
    flush = 1'b0;
    alu_control = 4'd0;
    @(negedge clk);
    chk("after_flush_busy", W'(busy), W'(0));
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    chk("flush_no_result", W'(seen), W'(0));
    do_mul(64'd3, 64'd4, n, r, got);
    chk("mul3x4_done", W'(got), W'(1));
    chk("mul3x4_result", r, 64'd12);

    // Asynchronous reset in BUSY cycle 30
    @(posedge clk); #1;
    alu_control = 4'd8; operand_a = '1; operand_b = '1; en = 1'b1;
    repeat (30) @(posedge clk);
    #3;
    chk("pre_reset_busy", W'(busy), W'(1));
    arst = 1'b1;
    #1;
    chk("arst_stall", W'(stall), W'(0));
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_valid", W'(result_valid), W'(0));
    chk("arst_result", result, '0);
    @(posedge clk); #1;
    alu_control = 4'd0;
    #2;
    arst = 1'b0;
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (result_valid || busy) seen = 1'b1;
    end
    chk("after_reset_idle", W'(seen), W'(0));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish before t=200000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
